sum_requester: RTL and testbench
================================

Name: sum_requester

Overview:
- Initiator/host side of the four-word summing device.
- Accepts 8-bit words one at a time over a valid/ready input stream and packs four of them into the 32-bit operand bus.
- Issues a one-cycle start pulse, then waits for the device's single-cycle result strobe and captures the 10-bit sum.
- Presents the sum to a downstream consumer over a valid/ready handshake; aborts with an error flag if the device never answers.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before aborting; must be ≥ 6.
- TIMEOUT_WIDTH, 5: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- async_reset  input  1  asynchronous, active-high reset
- in_data  input  8  next word to be summed
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- data_to_calculate  output  32  packed operands to device; word i on bits [8i+7:8i]
- start_calculating  output  1  one-cycle start pulse to device
- valid_output  input  1  device result strobe
- data_output  input  10  device result
- res_data  output  10  captured sum
- res_valid  output  1  res_data valid
- res_ready  input  1  consumer accepts res_data
- busy  output  1  high in every state except COLLECT
- timeout_error  output  1  sticky flag: last request timed out

Behaviour:
- Reset (async, active-high): state=COLLECT, word index=0, data_to_calculate=0, res_data=0, wait counter=0. All outputs low except in_ready, which is high (state-decoded).
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- COLLECT:
  - in_ready=1. A transfer occurs when in_valid&&in_ready.
  - On each transfer, in_data is written into lane [index] and index increments.
  - The transfer at index=0 clears timeout_error.
  - The transfer at index=3 wraps index to 0 and moves to START.
  - Lanes not yet rewritten keep their old values.
- START:
  - start_calculating=1 for exactly this one cycle; in_ready=0.
  - Next state is WAIT; wait counter cleared.
  - data_to_calculate is stable from START until the next COLLECT transfer.
- WAIT:
  - in_ready=0. The wait counter increments each cycle.
  - If valid_output=1: data_output is captured into res_data; next state is DELIVER.
  - Else if the counter reaches TIMEOUT_CYCLES-1: timeout_error is set, next state is COLLECT, and res_valid is never raised.
  - A valid_output on the same cycle as the timeout wins; the result is captured.
- DELIVER:
  - res_valid=1 and res_data is held stable until res_ready=1.
  - On res_valid&&res_ready: next state is COLLECT; res_valid is low the following cycle.
  - in_ready=0 throughout (no overlap of transactions).
- valid_output outside WAIT is ignored and does not change res_data.
- The device answers 5 cycles after start_calculating (4 calculate cycles + 1 show cycle); the default timeout gives margin.
- Minimum transaction length: 4 input cycles + 1 START + 5 WAIT + 1 DELIVER = 11 cycles.
- Reset asserted in any state returns immediately to reset values. A pending result is discarded, and any partially collected words are discarded (index=0).

Optional Feature:
- Macro SUM_CHECK_EN.
- When defined:
  - An extra output port, sum_mismatch (1 bit), is added.
  - In START, the block registers its own 10-bit sum of the four lanes (zero-extended add).
  - On capture in WAIT, sum_mismatch is set if data_output differs from that sum; it is cleared on capture of a matching result.
  - sum_mismatch is held through DELIVER and reset to 0.
- When undefined: the port, the adder and the register are absent, and behaviour is otherwise identical.

Test Plan:
- Bytes 0x01,0x02,0x03,0x04 with in_valid continuous -> data_to_calculate=0x04030201, start_calculating high exactly 1 cycle; device model returns 0x00A 5 cycles later -> res_data=0x00A, res_valid=1.
- Bytes 0xFF ×4 with in_valid toggling every other cycle -> only 4 transfers counted, data_to_calculate=0xFFFFFFFF, res_data=0x3FC.
- res_ready held low 3 cycles in DELIVER -> res_valid and res_data stable, in_ready=0, busy=1; res_ready=1 -> COLLECT next cycle, in_ready=1.
- Device model silent after start -> timeout_error=1 after 16 WAIT cycles, back in COLLECT, res_valid never high; next accepted byte clears timeout_error.
- async_reset pulsed during WAIT and after 2 of 4 bytes in COLLECT -> all outputs at reset values, index 0; a following full transaction completes correctly.
- SUM_CHECK_EN defined, bytes 0x01..0x04, device returns 0x00B -> sum_mismatch=1 with res_data=0x00B; next transaction with correct 0x00A -> sum_mismatch=0.

Source files
------------

// File: rtl/sum_requester.sv
//============================================================================
// Module   : sum_requester
// Purpose  : Host side of the four-word summing device. Packs four 8-bit
//            words, pulses start, captures the 10-bit result and hands it
//            downstream. Optional macro SUM_CHECK_EN adds a local sum
//            cross-check (sum_mismatch output).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module sum_requester #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_WIDTH  = 5
) (
    input  logic        clk,
    input  logic        async_reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] data_to_calculate,
    output logic        start_calculating,
    input  logic        valid_output,
    input  logic [9:0]  data_output,
    output logic [9:0]  res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        timeout_error
`ifdef SUM_CHECK_EN
    ,
    output logic        sum_mismatch
`endif
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] C_CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic [31:0]              data_q, data_d;
    logic [9:0]               res_q, res_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     tmo_q, tmo_d;
`ifdef SUM_CHECK_EN
    logic [9:0]               sum_q, sum_d;
    logic                     mism_q, mism_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`ifdef SUM_CHECK_EN
        sum_d   = sum_q;
        mism_d  = mism_q;
`endif
        case (state_q)
            S_COLLECT: begin
                if (in_valid) begin
                    data_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd0) tmo_d = 1'b0;
                    if (idx_q == 2'd3) state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
`ifdef SUM_CHECK_EN
                sum_d = {2'b00, data_q[7:0]}   + {2'b00, data_q[15:8]} +
                        {2'b00, data_q[23:16]} + {2'b00, data_q[31:24]};
`endif
            end
            S_WAIT: begin
                cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                // A result arriving on the timeout cycle still wins.
                if (valid_output) begin
                    res_d   = data_output;
                    state_d = S_DELIVER;
`ifdef SUM_CHECK_EN
                    mism_d  = (data_output != sum_q);
`endif
                end else if (cnt_q == C_CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_COLLECT;
                end
            end
            S_DELIVER: begin
                if (res_ready) state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= S_COLLECT;
            idx_q   <= 2'd0;
            data_q  <= 32'd0;
            res_q   <= 10'd0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`ifdef SUM_CHECK_EN
            sum_q   <= 10'd0;
            mism_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`ifdef SUM_CHECK_EN
            sum_q   <= sum_d;
            mism_q  <= mism_d;
`endif
        end
    end

    // Handshake outputs are decoded from the state register only.
    assign in_ready          = (state_q == S_COLLECT);
    assign start_calculating = (state_q == S_START);
    assign res_valid         = (state_q == S_DELIVER);
    assign busy              = (state_q != S_COLLECT);
    assign data_to_calculate = data_q;
    assign res_data          = res_q;
    assign timeout_error     = tmo_q;
`ifdef SUM_CHECK_EN
    assign sum_mismatch      = mism_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sum_requester.sv
//============================================================================
// Module   : tb_sum_requester
// Purpose  : Scoreboard bench for sum_requester with a behavioural device
//            that answers five cycles after each start pulse.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_sum_requester;

    logic        clk = 1'b0;
    logic        async_reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_to_calculate;
    logic        start_calculating;
    logic        valid_output;
    logic [9:0]  data_output;
    logic [9:0]  res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        timeout_error;
`ifdef SUM_CHECK_EN
    logic        sum_mismatch;
`endif

    typedef struct packed {
        logic [9:0] res;
        logic       mism;
    } res_t;

    logic [31:0] op_q[$];
    res_t        res_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        dev_enable;
    logic [9:0]  dev_answer;

    sum_requester #(.TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5)) dut (
        .clk               (clk),
        .async_reset       (async_reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .data_to_calculate (data_to_calculate),
        .start_calculating (start_calculating),
        .valid_output      (valid_output),
        .data_output       (data_output),
        .res_data          (res_data),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .busy              (busy),
        .timeout_error     (timeout_error)
`ifdef SUM_CHECK_EN
        ,
        .sum_mismatch      (sum_mismatch)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},      {31'd0, in_ready},          32'd1);
        chk({tag, "_start"},         {31'd0, start_calculating}, 32'd0);
        chk({tag, "_res_valid"},     {31'd0, res_valid},         32'd0);
        chk({tag, "_busy"},          {31'd0, busy},              32'd0);
        chk({tag, "_timeout_error"}, {31'd0, timeout_error},     32'd0);
        chk({tag, "_operands"},      data_to_calculate,          32'd0);
        chk({tag, "_res_data"},      {22'd0, res_data},          32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [7:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_msg("send_bound");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_msg("idle_bound");
        @(posedge clk);
        #1;
    endtask

    task automatic transaction(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [9:0] ans, input logic mism);
        dev_answer = ans;
        op_q.push_back({b3, b2, b1, b0});
        res_q.push_back('{res: ans, mism: mism});
        send(b0);
        send(b1);
        send(b2);
        send(b3);
        wait_idle();
    endtask

    // Behavioural device: strobe valid_output five cycles after start.
    initial begin
        valid_output = 1'b0;
        data_output  = 10'd0;
        forever begin
            @(negedge clk);
            if (start_calculating && dev_enable && !async_reset) begin
                repeat (5) @(posedge clk);
                #1;
                valid_output = 1'b1;
                data_output  = dev_answer;
                @(posedge clk);
                #1;
                valid_output = 1'b0;
                data_output  = 10'h155;
            end
        end
    end

    // Monitor: operands at each start pulse, results at each handshake.
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (async_reset) begin
                prev_start = 1'b0;
            end else begin
                if (start_calculating) begin
                    if (prev_start) fail_msg("start_pulse_width");
                    if (op_q.size() == 0) fail_msg("unexpected_start");
                    else chk("operands", data_to_calculate, op_q.pop_front());
                end
                prev_start = start_calculating;
                if (res_valid && res_ready) begin
                    if (res_q.size() == 0) begin
                        fail_msg("unexpected_result");
                    end else begin
                        res_t e;
                        e = res_q.pop_front();
                        chk("result", {22'd0, res_data}, {22'd0, e.res});
`ifdef SUM_CHECK_EN
                        chk("sum_mismatch", {31'd0, sum_mismatch}, {31'd0, e.mism});
`endif
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        async_reset = 1'b1;
        in_data     = 8'd0;
        in_valid    = 1'b0;
        res_ready   = 1'b1;
        dev_enable  = 1'b1;
        dev_answer  = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        async_reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_released");
        @(posedge clk);
        #1;

        // Continuous valid, basic sum.
        transaction(8'h01, 8'h02, 8'h03, 8'h04, 10'h00A, 1'b0);

        // Valid toggling; idle cycles carry junk that must be ignored.
        dev_answer = 10'h3FC;
        op_q.push_back(32'hFFFF_FFFF);
        res_q.push_back('{res: 10'h3FC, mism: 1'b0});
        for (int i = 0; i < 4; i++) begin
            send(8'hFF);
            in_data = 8'h55;
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Consumer back-pressure in DELIVER.
        res_ready  = 1'b0;
        dev_answer = 10'h0A0;
        op_q.push_back(32'h4030_2010);
        res_q.push_back('{res: 10'h0A0, mism: 1'b0});
        send(8'h10);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) fail_msg("deliver_bound");
        for (int i = 0; i < 3; i++) begin
            chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_res_data",  {22'd0, res_data},  32'h0A0);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_busy",      {31'd0, busy},      32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("handshake_res_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        chk("after_hs_in_ready",  {31'd0, in_ready},  32'd1);
        chk("after_hs_res_valid", {31'd0, res_valid}, 32'd0);
        chk("after_hs_busy",      {31'd0, busy},      32'd0);
        @(posedge clk);
        #1;

        // Silent device: 16 WAIT cycles then abort.
        dev_enable = 1'b0;
        op_q.push_back(32'h0D0C_0B0A);
        send(8'h0A);
        send(8'h0B);
        send(8'h0C);
        send(8'h0D);
        @(negedge clk);
        chk("tmo_start_seen", {31'd0, start_calculating}, 32'd1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (res_valid) fail_msg("tmo_res_valid_raised");
            if (in_ready) break;
        end
        chk("tmo_cycles_to_collect", n, 32'd17);
        chk("tmo_error_set", {31'd0, timeout_error}, 32'd1);
        chk("tmo_in_ready",  {31'd0, in_ready},      32'd1);
        @(posedge clk);
        #1;
        dev_enable = 1'b1;
        dev_answer = 10'h004;
        op_q.push_back(32'h0101_0101);
        res_q.push_back('{res: 10'h004, mism: 1'b0});
        send(8'h01);
        @(negedge clk);
        chk("tmo_error_cleared", {31'd0, timeout_error}, 32'd0);
        @(posedge clk);
        #1;
        send(8'h01);
        send(8'h01);
        send(8'h01);
        wait_idle();

        // Reset during WAIT; the late device strobe must be ignored.
        dev_answer = 10'h0AA;
        op_q.push_back(32'h4433_2211);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        repeat (2) @(posedge clk);
        #2;
        async_reset = 1'b1;
        #1;
        check_reset_vals("rst_in_wait");
        @(posedge clk);
        #1;
        async_reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("late_strobe_res_data",  {22'd0, res_data},  32'd0);
        chk("late_strobe_res_valid", {31'd0, res_valid}, 32'd0);
        chk("late_strobe_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;

        // Reset after two of four words.
        send(8'hAA);
        send(8'hBB);
        #2;
        async_reset = 1'b1;
        #1;
        check_reset_vals("rst_in_collect");
        @(posedge clk);
        #1;
        async_reset = 1'b0;
        transaction(8'h05, 8'h06, 8'h07, 8'h08, 10'h01A, 1'b0);

        // Wrong then correct device answers.
        transaction(8'h01, 8'h02, 8'h03, 8'h04, 10'h00B, 1'b1);
        transaction(8'h01, 8'h02, 8'h03, 8'h04, 10'h00A, 1'b0);

        repeat (3) @(posedge clk);
        chk("ops_drained",     op_q.size(),  32'd0);
        chk("results_drained", res_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
